// File: rtl/product_collector.sv
`default_nettype none
// ============================================================================
//  Module      : product_collector
//  Description : Captures one product per rising edge of the multiplier's
//                done strobe into a small FIFO, and keeps a signed 24-bit
//                running sum of every product that was accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module product_collector #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                p_in,
    input  logic                       done_in,
    output logic [15:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [23:0]                acc,
    input  logic                       acc_clr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic              r_done_prev;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [23:0]       r_acc;
    logic              r_overflow;
    logic [15:0]       r_mem [DEPTH];

    logic              w_capture;
    logic              w_pop;
    logic              w_full;
    logic              w_valid;
    logic              w_accept;
    logic              w_drop;
    logic [23:0]       w_p_ext;

    // Status flags come only from the registered occupancy, so neither
    // out_ready nor done_in can reach full/out_valid combinationally.
    assign w_full    = (r_count == c_DEPTH);
    assign w_valid   = (r_count != '0);

    // A held strobe counts once: only its rising edge is a capture.
    assign w_capture = done_in & ~r_done_prev;
    assign w_pop     = w_valid & out_ready;

    // When full, a simultaneous pop frees the slot the capture needs.
    assign w_accept  = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

    assign w_p_ext   = {{8{p_in[15]}}, p_in};

    // Head is forced to zero while empty so the output is clean out of reset
    // even though the storage array itself carries no reset.
    assign out_data  = w_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign out_valid = w_valid;
    assign full      = w_full;
    assign count     = r_count;
    assign acc       = r_acc;
    assign overflow  = r_overflow;

    // Done-strobe history for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_prev <= 1'b0;
        end else begin
            r_done_prev <= done_in;
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointer wrap free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; written only on an accepted capture.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= p_in;
        end
    end

    // Running sum; a clear restarts from the product accepted on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= 24'h000000;
        end else if (acc_clr) begin
            r_acc <= w_accept ? w_p_ext : 24'h000000;
        end else if (w_accept) begin
            r_acc <= r_acc + w_p_ext;
        end
    end

    // Sticky drop flag; a drop on the clearing edge keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_product_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_collector
//  Description : Self-checking bench for product_collector. Accepted products
//                are queued in a scoreboard and compared against the FIFO head
//                as they are popped; occupancy, flags and sum track a model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_product_collector;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [15:0]   p_in;
    logic          done_in;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [23:0]   acc;
    logic          acc_clr;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          ovf_clr;

    product_collector #(.DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .p_in      (p_in),
        .done_in   (done_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .acc_clr   (acc_clr),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state.
    logic [15:0] sb_q[$];
    int          m_count;
    logic [23:0] m_acc;
    logic        m_ovf;
    logic        m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_acc   = 24'h0;
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
    endtask

    task automatic check_state();
        check("count", 32'(count), 32'(m_count));
        check("valid", 32'(out_valid), 32'(m_count != 0));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("ovf", 32'(overflow), 32'(m_ovf));
        check("acc", 32'(acc), 32'(m_acc));
        if (sb_q.size() > 0) check("head", 32'(out_data), 32'(sb_q[0]));
    endtask

    // One clock: drive inputs in the low phase, predict the edge, check at
    // the following falling edge.
    task automatic cycle(input logic d, input logic [15:0] p, input logic rdy,
                         input logic aclr = 1'b0, input logic oclr = 1'b0);
        logic cap, mfull, pop, accept, drop;
        logic [23:0] ext;
        done_in   = d;
        p_in      = p;
        out_ready = rdy;
        acc_clr   = aclr;
        ovf_clr   = oclr;
        #1;
        cap    = d && !m_prev;
        mfull  = (m_count == DEPTH);
        pop    = (m_count != 0) && rdy;
        accept = cap && (!mfull || pop);
        drop   = cap && mfull && !pop;
        ext    = {{8{p[15]}}, p};
        if (pop) begin
            check("pop_data", 32'(out_data), 32'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (accept) sb_q.push_back(p);
        m_count = m_count + (accept ? 1 : 0) - (pop ? 1 : 0);
        if (aclr)        m_acc = accept ? ext : 24'h0;
        else if (accept) m_acc = m_acc + ext;
        if (drop)        m_ovf = 1'b1;
        else if (oclr)   m_ovf = 1'b0;
        m_prev = d;
        @(negedge clk);
        check_state();
    endtask

    initial begin
        rst = 1'b0; p_in = '0; done_in = 1'b0; out_ready = 1'b0;
        acc_clr = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single product, then pop from empty afterwards.
        cycle(1, 16'h016C, 0);
        check("single_data", 32'(out_data), 32'h016C);
        check("single_count", 32'(count), 32'd1);
        check("single_acc", 32'(acc), 32'h00016C);
        cycle(0, 16'h0, 1);
        cycle(0, 16'h0, 1);
        check("pop_empty_count", 32'(count), 32'd0);

        // Signed sum with consumer always ready.
        cycle(0, 16'h0, 1, 1);
        cycle(1, 16'hFF9C, 1);
        cycle(0, 16'h0, 1);
        cycle(1, 16'h016C, 1);
        cycle(0, 16'h0, 1);
        cycle(0, 16'h0, 1);
        check("signed_acc", 32'(acc), 32'h000108);

        // Held strobe produces exactly one entry.
        cycle(0, 16'h0, 0, 1);
        repeat (3) cycle(1, 16'h0005, 0);
        cycle(0, 16'h0, 0);
        check("held_count", 32'(count), 32'd1);
        check("held_acc", 32'(acc), 32'd5);
        cycle(0, 16'h0, 1);

        // Overflow: five captures into a depth-4 FIFO.
        cycle(0, 16'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'h0001, 0);
            cycle(0, 16'h0001, 0);
        end
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_acc", 32'(acc), 32'd4);
        cycle(0, 16'h0, 0, 0, 1);
        check("ovf_clr", 32'(overflow), 32'd0);
        check("ovf_retained", 32'(count), 32'd4);

        // Capture and pop together while full.
        cycle(1, 16'h00AA, 1);
        check("fullpop_count", 32'(count), 32'd4);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        cycle(0, 16'h0, 0);

        // Drop on the same edge as ovf_clr keeps the flag.
        cycle(1, 16'h0007, 0, 0, 1);
        check("drop_wins", 32'(overflow), 32'd1);
        cycle(0, 16'h0, 0, 0, 1);

        // Drain, then clear the sum on the same edge as a capture.
        repeat (4) cycle(0, 16'h0, 1);
        cycle(1, 16'h0003, 0, 1);
        check("clr_cap_acc", 32'(acc), 32'd3);
        cycle(0, 16'h0, 1, 1);

        // Mid-run asynchronous reset with three entries held.
        cycle(1, 16'h0005, 0); cycle(0, 16'h0, 0);
        cycle(1, 16'h0005, 0); cycle(0, 16'h0, 0);
        cycle(1, 16'h0006, 0); cycle(0, 16'h0, 0);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_acc", 32'(acc), 32'h000010);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_acc", 32'(acc), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 16'h0002, 0);
        check("post_rst_acc", 32'(acc), 32'd2);
        check("post_rst_count", 32'(count), 32'd1);
        cycle(0, 16'h0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/product_collector.md
PRODUCT_COLLECTOR -- requirements
Module: product_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the reset port is named rst, following the codebase's clock/reset port names.
REQ-002 Parameter: DEPTH, default 4, number of FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  rising-edge clock shared with the upstream multiplier.
REQ-004 rst  input  1  asynchronous reset, active low.
REQ-005 p_in  input  16  signed product from the upstream multiplier; valid while done_in is high.
REQ-006 done_in  input  1  multiplier completion strobe; may stay high for one or more cycles.
REQ-007 out_data  output  16  product at the FIFO head.
REQ-008 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 acc  output  24  signed running sum of accepted products.
REQ-011 acc_clr  input  1  synchronous clear of acc.
REQ-012 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 full  output  1  count == DEPTH.
REQ-014 overflow  output  1  sticky flag: a product was dropped.
REQ-015 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-016 A capture event SHALL be done_in high while the registered done_prev is low (rising-edge detect); a done_in held high for N cycles yields exactly one capture.
REQ-017 A pop SHALL occur when out_valid and out_ready are both high on a clock edge.
REQ-018 A capture with full low SHALL write p_in at the write pointer, and out_valid SHALL be high from the next cycle; there is no same-cycle bypass.
REQ-019 A capture with full high and no pop SHALL drop p_in, set overflow, leave acc unchanged, and leave count unchanged.
REQ-020 A capture and a pop on the same edge while full SHALL both proceed; count stays at DEPTH and overflow is not set.
REQ-021 A capture and a pop on the same edge with 0 < count < DEPTH SHALL keep count unchanged.
REQ-022 A pop while empty SHALL be ignored; pointers and count stay unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 out_data SHALL present the oldest entry, in FIFO order.
REQ-025 Each accepted capture SHALL update acc <= acc + sign_extend24(p_in), with wrap-around modulo 2^24.
REQ-026 acc_clr SHALL take priority over accumulation: acc <= 0, or acc <= sign_extend24(p_in) if a capture is accepted on the same edge.
REQ-027 ovf_clr SHALL clear overflow; a drop on the same edge SHALL win and leave overflow set.
REQ-028 full and out_valid SHALL be derived from registered count only, with no combinational path from out_ready or done_in.

Reset
REQ-029 While rst is low, the block SHALL force: done_prev=0, pointers=0, count=0, out_valid=0, full=0, overflow=0, acc=0, out_data=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries immediately; after release, the first capture requires a new done_in rising edge.

Verification
REQ-031 Single product: p_in=0x016C with a one-cycle done_in -> next cycle out_valid=1, out_data=0x016C, count=1, acc=0x00016C.
REQ-032 Signed sum: capture 0xFF9C (-100), then 0x016C (364), with out_ready=1 -> outputs appear in that order, acc=0x000108.
REQ-033 Held strobe: done_in high for 3 cycles with p_in=0x0005 -> exactly one entry, acc=5.
REQ-034 Overflow with DEPTH=4 and out_ready=0: five captures of 0x0001 -> count=4, full=1, overflow=1, acc=4; then ovf_clr -> overflow=0 while the entries are retained.
REQ-035 Full plus simultaneous pop: capture and pop on the same edge while full -> count=4, overflow=0, head advances by one.
REQ-036 Reset mid-run: rst low with count=3 and acc=0x000010 -> all outputs zero asynchronously; a later capture of 0x0002 -> acc=2, count=1.
